// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared definitions for the two-master RAM arbiter.
//   - arbState_t  : transaction FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//   - NUM_MASTERS : number of bus masters sharing the RAM
//   - CPU / DMA   : master index constants, also the bit positions in grant
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbState_t;

    localparam int NUM_MASTERS = 2;
    localparam int CPU         = 0;
    localparam int DMA         = 1;

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// rr_picker
//   Combinational two-way round-robin selector.
//   Ports:
//     req       in  [NUM_MASTERS] request vector, bit CPU = master 0, bit DMA = master 1
//     lastGrant in  1             index of the master granted most recently
//     pick      out [NUM_MASTERS] one-hot winner, all zero when nobody requests
//   A lone requester always wins. When both request, the master that was
//   not granted last wins, so neither master can starve the other.
module rr_picker
    import ram_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   lastGrant,
    output logic [NUM_MASTERS-1:0] pick
);

    always_comb begin
        pick = '0;
        if (req[CPU] && req[DMA]) begin
            // Tie: hand the bus to whoever did not have it last time.
            if (lastGrant == 1'(DMA)) begin
                pick[CPU] = 1'b1;
            end else begin
                pick[DMA] = 1'b1;
            end
        end else if (req[CPU]) begin
            pick[CPU] = 1'b1;
        end else if (req[DMA]) begin
            pick[DMA] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port RAM between a CPU (master 0) and a DMA engine
//   (master 1). Each transaction takes exactly three cycles:
//     IDLE   : sample requests, pick a winner, latch its command
//     ACCESS : command is on the RAM bus, read data is captured
//     DONE   : one-cycle ready pulse to the winner with the captured data
//   Request/ready handshake: a master raises mN_req with its command; the
//   request is taken only in IDLE and the command is latched at that edge,
//   so the master may change or drop its inputs afterwards. Completion is a
//   single-cycle mN_ready pulse two cycles after acceptance, with read data
//   valid on mN_rData in that same cycle. A request still high in the next
//   IDLE cycle starts a new transaction.
//
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     mN_req/we/addr/wData/func3   master N command inputs
//     mN_ready, mN_rData    master N completion pulse and read data
//     busWe, busAddr, busWData, busFunc3   RAM command outputs
//     busRData              RAM combinational read data
//     grant                 one-hot owner of the current transaction, 0 when idle
//     dbgState              current FSM state, for observation only
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [ADDR_W-1:0]      m0_addr,
    input  logic [DATA_W-1:0]      m0_wData,
    input  logic [2:0]             m0_func3,
    output logic                   m0_ready,
    output logic [DATA_W-1:0]      m0_rData,

    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [ADDR_W-1:0]      m1_addr,
    input  logic [DATA_W-1:0]      m1_wData,
    input  logic [2:0]             m1_func3,
    output logic                   m1_ready,
    output logic [DATA_W-1:0]      m1_rData,

    output logic                   busWe,
    output logic [ADDR_W-1:0]      busAddr,
    output logic [DATA_W-1:0]      busWData,
    output logic [2:0]             busFunc3,
    input  logic [DATA_W-1:0]      busRData,

    output logic [NUM_MASTERS-1:0] grant,
    output logic [1:0]             dbgState
);

    arbState_t               state;
    logic                    lastGrant;   // index of the last master served
    logic [DATA_W-1:0]       rData;       // read data captured during ACCESS
    logic [NUM_MASTERS-1:0]  pick;

    // Command of the winning master, selected combinationally in IDLE.
    logic                    selWe;
    logic [ADDR_W-1:0]       selAddr;
    logic [DATA_W-1:0]       selWData;
    logic [2:0]              selFunc3;

    rr_picker uPicker (
        .req       ({m1_req, m0_req}),
        .lastGrant (lastGrant),
        .pick      (pick)
    );

    always_comb begin
        selWe    = m0_we;
        selAddr  = m0_addr;
        selWData = m0_wData;
        selFunc3 = m0_func3;
        if (pick[DMA]) begin
            selWe    = m1_we;
            selAddr  = m1_addr;
            selWData = m1_wData;
            selFunc3 = m1_func3;
        end
    end

    // The bus address/data/func3 registers double as the latched command:
    // they are loaded once on acceptance and simply hold afterwards, so the
    // RAM sees a stable command for the whole transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            busWe     <= 1'b0;
            busAddr   <= '0;
            busWData  <= '0;
            busFunc3  <= '0;
            rData     <= '0;
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
            // Pretend DMA went last so the first tie goes to the CPU.
            lastGrant <= 1'(DMA);
        end else begin
            case (state)
                IDLE: begin
                    if (|pick) begin
                        grant    <= pick;
                        busWe    <= selWe;
                        busAddr  <= selAddr;
                        busWData <= selWData;
                        busFunc3 <= selFunc3;
                        state    <= ACCESS;
                    end
                end

                ACCESS: begin
                    // Write strobe lasts exactly this one cycle.
                    busWe    <= 1'b0;
                    rData    <= busRData;
                    m0_ready <= grant[CPU];
                    m1_ready <= grant[DMA];
                    state    <= DONE;
                end

                DONE: begin
                    m0_ready  <= 1'b0;
                    m1_ready  <= 1'b0;
                    lastGrant <= grant[DMA];
                    grant     <= '0;
                    state     <= IDLE;
                end

                default: begin
                    busWe    <= 1'b0;
                    m0_ready <= 1'b0;
                    m1_ready <= 1'b0;
                    grant    <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Both masters see the same captured word; only the one pulsing ready
    // is expected to look at it.
    assign m0_rData = rData;
    assign m1_rData = rData;
    assign dbgState = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed scenarios for the arbiter plus a randomized run against a
//   transaction-level reference model. The bench owns a small RAM that the
//   DUT bus drives; the reference model keeps its own copy of memory.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wData, m1_wData;
    logic [2:0]    m0_func3, m1_func3;
    logic          m0_ready, m1_ready;
    logic [DW-1:0] m0_rData, m1_rData;
    logic          busWe;
    logic [AW-1:0] busAddr;
    logic [DW-1:0] busWData;
    logic [2:0]    busFunc3;
    logic [DW-1:0] busRData;
    logic [1:0]    grant;
    logic [1:0]    dbgState;
    logic [1:0]    readyV;

    int nChecks = 0;
    int nFails  = 0;

    // RAM behind the bus: 64 words, combinational read, write on clock edge.
    logic [DW-1:0] ram    [0:63];
    logic [DW-1:0] refMem [0:63];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (busWe) ram[busAddr[7:2]] <= busWData;
    end
    assign busRData = ram[busAddr[7:2]];
    assign readyV   = {m1_ready, m0_ready};

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wData(m0_wData),
        .m0_func3(m0_func3), .m0_ready(m0_ready), .m0_rData(m0_rData),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wData(m1_wData),
        .m1_func3(m1_func3), .m1_ready(m1_ready), .m1_rData(m1_rData),
        .busWe(busWe), .busAddr(busAddr), .busWData(busWData), .busFunc3(busFunc3),
        .busRData(busRData), .grant(grant), .dbgState(dbgState)
    );

    task automatic test_reset();
        reset = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wData = '0; m0_func3 = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wData = '0; m1_func3 = '0;
        repeat (2) @(negedge clk);
        nChecks++; if (grant !== 2'b00) begin nFails++; $display("FAIL reset_grant: got %b want 00", grant); end
        nChecks++; if (busWe !== 1'b0) begin nFails++; $display("FAIL reset_busWe: got %b want 0", busWe); end
        nChecks++; if (readyV !== 2'b00) begin nFails++; $display("FAIL reset_ready: got %b want 00", readyV); end
        nChecks++; if (busAddr !== 32'h0) begin nFails++; $display("FAIL reset_busAddr: got %h want 0", busAddr); end
        nChecks++; if (busWData !== 32'h0) begin nFails++; $display("FAIL reset_busWData: got %h want 0", busWData); end
        nChecks++; if (busFunc3 !== 3'h0) begin nFails++; $display("FAIL reset_busFunc3: got %h want 0", busFunc3); end
        nChecks++; if (dbgState !== IDLE) begin nFails++; $display("FAIL reset_state: got %0d want %0d", dbgState, IDLE); end
        reset = 1'b0;
    endtask

    // Called right after reset release: the very first edge must take it.
    task automatic test_write();
        int weCount = 0;
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wData = 32'hDEADBEEF; m0_func3 = 3'd2;
        @(negedge clk);
        weCount += int'(busWe);
        nChecks++; if (grant !== 2'b01) begin nFails++; $display("FAIL write_grant: got %b want 01", grant); end
        nChecks++; if (busWe !== 1'b1) begin nFails++; $display("FAIL write_busWe: got %b want 1", busWe); end
        nChecks++; if (busAddr !== 32'h10) begin nFails++; $display("FAIL write_busAddr: got %h want 10", busAddr); end
        nChecks++; if (busWData !== 32'hDEADBEEF) begin nFails++; $display("FAIL write_busWData: got %h want deadbeef", busWData); end
        nChecks++; if (busFunc3 !== 3'd2) begin nFails++; $display("FAIL write_busFunc3: got %0d want 2", busFunc3); end
        nChecks++; if (readyV !== 2'b00) begin nFails++; $display("FAIL write_early_ready: got %b want 00", readyV); end
        m0_req = 0; m0_addr = $urandom; m0_wData = $urandom; m0_we = 0;
        @(negedge clk);
        weCount += int'(busWe);
        nChecks++; if (readyV !== 2'b01) begin nFails++; $display("FAIL write_ready: got %b want 01", readyV); end
        @(negedge clk);
        weCount += int'(busWe);
        nChecks++; if (readyV !== 2'b00) begin nFails++; $display("FAIL write_ready_drop: got %b want 00", readyV); end
        nChecks++; if (grant !== 2'b00) begin nFails++; $display("FAIL write_grant_clear: got %b want 00", grant); end
        nChecks++; if (weCount != 1) begin nFails++; $display("FAIL write_we_cycles: got %0d want 1", weCount); end
    endtask

    task automatic test_read();
        m1_req = 1; m1_we = 0; m1_addr = 32'h10; m1_wData = $urandom; m1_func3 = 3'd2;
        @(negedge clk);
        nChecks++; if (grant !== 2'b10) begin nFails++; $display("FAIL read_grant: got %b want 10", grant); end
        nChecks++; if (busWe !== 1'b0) begin nFails++; $display("FAIL read_busWe: got %b want 0", busWe); end
        m1_req = 0;
        @(negedge clk);
        nChecks++; if (readyV !== 2'b10) begin nFails++; $display("FAIL read_ready: got %b want 10", readyV); end
        nChecks++; if (m1_rData !== 32'hDEADBEEF) begin nFails++; $display("FAIL read_data: got %h want deadbeef", m1_rData); end
        nChecks++; if (grant !== 2'b10) begin nFails++; $display("FAIL read_grant_done: got %b want 10", grant); end
        @(negedge clk);
        nChecks++; if (readyV !== 2'b00) begin nFails++; $display("FAIL read_ready_drop: got %b want 00", readyV); end
    endtask

    // Both masters hold req high; last served was m1, so m0 goes first.
    task automatic test_alternate();
        logic [1:0] expG;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h14;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            expG = (((cyc - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (cyc % 3 == 1) begin
                nChecks++; if (grant !== expG) begin nFails++; $display("FAIL alt_grant cyc %0d: got %b want %b", cyc, grant, expG); end
            end
            if (cyc % 3 == 2) begin
                nChecks++; if (readyV !== expG) begin nFails++; $display("FAIL alt_ready cyc %0d: got %b want %b", cyc, readyV, expG); end
            end else begin
                nChecks++; if (readyV !== 2'b00) begin nFails++; $display("FAIL alt_no_ready cyc %0d: got %b want 00", cyc, readyV); end
            end
        end
        m0_req = 0; m1_req = 0;
    endtask

    task automatic test_addr_change();
        m0_req = 1; m0_we = 0; m0_addr = 32'h20;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin m0_req = 0; m0_addr = 32'h30; end
            nChecks++; if (busAddr !== 32'h20) begin nFails++; $display("FAIL hold_addr cyc %0d: got %h want 20", cyc, busAddr); end
        end
    endtask

    task automatic test_reset_abort();
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wData = $urandom;
        @(negedge clk);
        nChecks++; if (busWe !== 1'b1) begin nFails++; $display("FAIL abort_pre_busWe: got %b want 1", busWe); end
        m1_req = 0;
        reset = 1'b1;
        #1;
        nChecks++; if (grant !== 2'b00) begin nFails++; $display("FAIL abort_grant: got %b want 00", grant); end
        nChecks++; if (busWe !== 1'b0) begin nFails++; $display("FAIL abort_busWe: got %b want 0", busWe); end
        nChecks++; if (readyV !== 2'b00) begin nFails++; $display("FAIL abort_ready: got %b want 00", readyV); end
        @(negedge clk);
        nChecks++; if (readyV !== 2'b00) begin nFails++; $display("FAIL abort_ready_late: got %b want 00", readyV); end
        reset = 1'b0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h10;
        @(negedge clk);
        nChecks++; if (grant !== 2'b01) begin nFails++; $display("FAIL abort_tie_grant: got %b want 01", grant); end
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        nChecks++; if (readyV !== 2'b01) begin nFails++; $display("FAIL abort_next_ready: got %b want 01", readyV); end
        @(negedge clk);
    endtask

    task automatic test_m1_only();
        m1_req = 1; m1_we = 0; m1_addr = 32'h10; m0_req = 0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (cyc % 3 == 1) begin
                nChecks++; if (grant !== 2'b10) begin nFails++; $display("FAIL m1only_grant cyc %0d: got %b want 10", cyc, grant); end
            end
            if (cyc % 3 == 2) begin
                nChecks++; if (readyV !== 2'b10) begin nFails++; $display("FAIL m1only_ready cyc %0d: got %b want 10", cyc, readyV); end
            end else begin
                nChecks++; if (readyV !== 2'b00) begin nFails++; $display("FAIL m1only_no_ready cyc %0d: got %b want 00", cyc, readyV); end
            end
        end
        m1_req = 0;
    endtask

    // Random traffic against a transaction-level model: a phase counter
    // (0 waiting, 1 on the bus, 2 completing), the rule-based winner choice,
    // and a private copy of memory.
    task automatic test_random();
        int            mPhase = 0;
        int            mOwner = 0;
        int            mLast  = 1;
        logic          mWe    = 1'b0;
        logic [AW-1:0] mAddr  = '0;
        logic [DW-1:0] mData  = '0;
        logic [2:0]    mF3    = '0;
        logic [DW-1:0] expRD  = '0;
        logic [1:0]    expGrant;
        logic [DW-1:0] ownRData;
        reset = 1'b1;
        m0_req = 0; m1_req = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) refMem[i] = ram[i];
        for (int c = 0; c < 200; c++) begin
            m0_req = 1'($urandom_range(0, 1)); m0_we = 1'($urandom_range(0, 1));
            m0_addr = 32'($urandom_range(0, 63)) << 2; m0_wData = $urandom; m0_func3 = 3'($urandom_range(0, 7));
            m1_req = 1'($urandom_range(0, 1)); m1_we = 1'($urandom_range(0, 1));
            m1_addr = 32'($urandom_range(0, 63)) << 2; m1_wData = $urandom; m1_func3 = 3'($urandom_range(0, 7));
            case (mPhase)
                0: if (m0_req || m1_req) begin
                    if (m0_req && m1_req) mOwner = 1 - mLast;
                    else mOwner = m1_req ? 1 : 0;
                    mWe   = (mOwner == 1) ? m1_we : m0_we;
                    mAddr = (mOwner == 1) ? m1_addr : m0_addr;
                    mData = (mOwner == 1) ? m1_wData : m0_wData;
                    mF3   = (mOwner == 1) ? m1_func3 : m0_func3;
                    mPhase = 1;
                end
                1: begin
                    if (mWe) refMem[mAddr[7:2]] = mData;
                    else expRD = refMem[mAddr[7:2]];
                    mPhase = 2;
                end
                default: begin
                    mLast = mOwner;
                    mPhase = 0;
                end
            endcase
            @(negedge clk);
            expGrant = (mPhase == 0) ? 2'b00 : ((mOwner == 1) ? 2'b10 : 2'b01);
            ownRData = (mOwner == 1) ? m1_rData : m0_rData;
            nChecks++; if (grant !== expGrant) begin nFails++; $display("FAIL rnd_grant c%0d: got %b want %b", c, grant, expGrant); end
            nChecks++; if (busWe !== (mPhase == 1 && mWe)) begin nFails++; $display("FAIL rnd_busWe c%0d: got %b want %b", c, busWe, (mPhase == 1 && mWe)); end
            nChecks++; if (busAddr !== mAddr) begin nFails++; $display("FAIL rnd_busAddr c%0d: got %h want %h", c, busAddr, mAddr); end
            nChecks++; if (busWData !== mData) begin nFails++; $display("FAIL rnd_busWData c%0d: got %h want %h", c, busWData, mData); end
            nChecks++; if (busFunc3 !== mF3) begin nFails++; $display("FAIL rnd_busFunc3 c%0d: got %h want %h", c, busFunc3, mF3); end
            nChecks++; if (readyV !== ((mPhase == 2) ? expGrant : 2'b00)) begin nFails++; $display("FAIL rnd_ready c%0d: got %b want %b", c, readyV, (mPhase == 2) ? expGrant : 2'b00); end
            if (mPhase == 2 && !mWe) begin
                nChecks++; if (ownRData !== expRD) begin nFails++; $display("FAIL rnd_rData c%0d: got %h want %h", c, ownRData, expRD); end
            end
        end
        m0_req = 0; m1_req = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alternate();
        test_addr_change();
        test_reset_abort();
        test_m1_only();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 32, bus address width; DATA_W, default 32, bus data width.
REQ-002 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports, per master N in {0 = CPU, 1 = DMA}: mN_req  input  1  transaction request.
REQ-005 SHALL have ports: mN_we  input  1  write, 0 = read.
REQ-006 SHALL have ports: mN_addr  input  ADDR_W  byte address.
REQ-007 SHALL have ports: mN_wData  input  DATA_W  write data.
REQ-008 SHALL have ports: mN_func3  input  3  access size/sign, passed to RAM unchanged.
REQ-009 SHALL have ports: mN_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports: mN_rData  output  DATA_W  read data, valid while mN_ready=1.
REQ-011 SHALL have ports: busWe  output  1; busAddr  output  ADDR_W; busWData  output  DATA_W; busFunc3  output  3; all driving the single-port RAM.
REQ-012 SHALL have port: busRData  input  DATA_W  RAM combinational read data.
REQ-013 SHALL have port: grant  output  2  one-hot owner of the current transaction, 0 when idle.

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; no other transitions except reset.
REQ-015 IDLE: if m0_req or m1_req, SHALL select one master, latch its we/addr/wData/func3, set grant, go ACCESS; otherwise stay IDLE.
REQ-016 Selection SHALL be round-robin: single requester wins; both requesting -> master not granted last wins; pointer after reset favours m0.
REQ-017 ACCESS: SHALL drive bus outputs from latched values; busWe=1 only in ACCESS and only for writes; SHALL register busRData into rData register; go DONE.
REQ-018 DONE: SHALL assert mN_ready=1 for granted master only, present registered data on mN_rData, update last-grant pointer, clear grant at exit, go IDLE.
REQ-019 Latency SHALL be fixed: req sampled at edge k, ready high in cycle k+2; throughput one transaction per 3 cycles.
REQ-020 Requests SHALL be sampled only in IDLE; req changes in ACCESS/DONE SHALL not affect current transaction; req still high in next IDLE is a new transaction.
REQ-021 Master inputs SHALL not be required stable after acceptance (latched in REQ-015).
REQ-022 Outside ACCESS: busWe=0, bus address/data/func3 hold latched values; ready of non-granted master always 0; mN_rData of non-ready master don't-care.
REQ-023 Both mN_ready SHALL never be 1 in the same cycle; grant SHALL always be one-hot or zero.

Reset
REQ-024 On reset assertion, asynchronously: state=IDLE, grant=0, busWe=0, m0_ready=m1_ready=0, latched addr/wData/func3/rData=0, pointer=favour m0.
REQ-025 Reset during ACCESS or DONE SHALL abort the transaction with no ready pulse; write in ACCESS cycle is not guaranteed to have completed.
REQ-026 First request SHALL be sampled at first rising edge after reset deassertion.

Structure
REQ-027 Shared package ram_arb_pkg SHALL hold the state enum (IDLE, ACCESS, DONE), master-count constant (2) and master index constants CPU=0, DMA=1.
REQ-028 One sub-module rr_picker (2 requests + last-grant in, one-hot grant out, combinational) SHALL implement REQ-016; everything else in ram_arbiter.

Verification
REQ-029 Reset, then m0 write addr 0x10 data 0xDEADBEEF func3 2 -> busWe=1 exactly one cycle, m0_ready at cycle 2, m1_ready stays 0.
REQ-030 m1 read addr 0x10 after REQ-029 -> m1_rData=0xDEADBEEF with m1_ready, grant=2'b10 during transaction.
REQ-031 m0 and m1 requesting continuously -> grants alternate 01,10,01,10; each ready spaced 3 cycles; first grant to m0.
REQ-032 m0 changes addr 0x20->0x30 during ACCESS -> busAddr stays 0x20 for whole transaction.
REQ-033 Reset asserted in ACCESS of m1 write -> no ready pulse, grant=0, busWe=0 immediately; next request after release granted to m0 on tie.
REQ-034 Only m1 requests three times -> m1 granted each time with no wait on absent m0.
